// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and widths for the set-associative data cache
package cache_pkg;

    typedef enum logic [1:0] {
        S_CMP   = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2
    } state_t;

    localparam int LINE_W      = 128;
    localparam int WORD_W      = 32;
    localparam int LINE_ADDR_W = 28;
    localparam int PROC_ADDR_W = 30;

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [1:0]        off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - true-LRU age tracking for one set; oldest way is the victim
module cache_lru
    import cache_pkg::*;
#(
    parameter int  WAYS  = 2,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             access_i,
    input  logic [WAY_W-1:0] way_i,
    output logic [WAY_W-1:0] victim_o
);

    logic [WAY_W-1:0] age_q [WAYS];
    logic [WAY_W-1:0] age_d [WAYS];

    // Ages always form a permutation of 0..WAYS-1, so exactly one way is oldest.
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            age_d[j] = age_q[j];
            if (access_i) begin
                if (WAY_W'(j) == way_i) begin
                    age_d[j] = '0;
                end else if (age_q[j] < age_q[way_i]) begin
                    age_d[j] = age_q[j] + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        victim_o = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (age_q[j] == WAY_W'(WAYS - 1)) begin
                victim_o = WAY_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < WAYS; j++) begin
                age_q[j] <= WAY_W'(j);
            end
        end else begin
            for (int j = 0; j < WAYS; j++) begin
                age_q[j] <= age_d[j];
            end
        end
    end

endmodule

// File: rtl/cache_setassoc.sv
// rtl/cache_setassoc.sv - write-back, write-allocate N-way set-associative data cache
module cache_setassoc
    import cache_pkg::*;
#(
    parameter int  WAYS  = 2,
    parameter int  SETS  = 4,
    parameter int  CNT_W = 32,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = LINE_ADDR_W - IDX_W,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   proc_reset_n,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [PROC_ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   proc_stall,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [LINE_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);

    localparam int ENT_W = IDX_W + WAY_W;
    localparam int ENT   = 1 << ENT_W;

    state_t           state_q;
    logic [ENT-1:0]   valid_q;
    logic [ENT-1:0]   dirty_q;
    logic [TAG_W-1:0] tag_q  [ENT];
    logic [LINE_W-1:0] data_q [ENT];
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             retry_q;
    logic [WAY_W-1:0] victim_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic             req;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_sel;
    logic [ENT_W-1:0] hit_ent;
    logic [ENT_W-1:0] vic_ent;
    logic [ENT_W-1:0] vic_sel_ent;
    logic             cmp_hit;
    logic [SETS-1:0]  lru_acc;
    logic [WAY_W-1:0] lru_victim [SETS];

    assign idx = proc_addr[1+IDX_W:2];
    assign tag = proc_addr[PROC_ADDR_W-1:2+IDX_W];
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;

    // Flat array entry for (set, way) is simply {set, way} since WAYS is a power of 2.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[{idx, WAY_W'(w)}] && (tag_q[{idx, WAY_W'(w)}] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[{idx, WAY_W'(w)}] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel  = inv_found ? inv_way : lru_victim[idx];
    assign hit_ent     = {idx, hit_way};
    assign vic_ent     = {idx, victim_q};
    assign vic_sel_ent = {idx, victim_sel};
    assign cmp_hit     = (state_q == S_CMP) && req && hit;

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        assign lru_acc[s] = cmp_hit && (idx == IDX_W'(s));
        cache_lru #(.WAYS(WAYS)) u_lru (
            .clk      (clk),
            .rst_n    (proc_reset_n),
            .access_i (lru_acc[s]),
            .way_i    (hit_way),
            .victim_o (lru_victim[s])
        );
    end

    assign proc_stall = (state_q != S_CMP) || (req && !hit);
    assign proc_rdata = ((state_q == S_CMP) && hit) ? line_word(data_q[hit_ent], off) : '0;
    // Strobes drop on mem_ready itself so the memory never sees a second request cycle.
    assign mem_write  = (state_q == S_WB) && !mem_ready;
    assign mem_read   = (state_q == S_ALLOC) && !mem_ready;
    assign mem_addr   = (state_q == S_WB)    ? {tag_q[vic_ent], idx} :
                        (state_q == S_ALLOC) ? proc_addr[PROC_ADDR_W-1:2] : '0;
    assign mem_wdata  = (state_q == S_WB) ? data_q[vic_ent] : '0;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q    <= S_CMP;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
            victim_q   <= '0;
        end else begin
            case (state_q)
                S_CMP: begin
                    if (req && hit) begin
                        if (proc_write) begin
                            dirty_q[hit_ent] <= 1'b1;
                        end
                        if (retry_q) begin
                            retry_q <= 1'b0;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end
                    end else if (req) begin
                        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        victim_q   <= victim_sel;
                        state_q    <= (valid_q[vic_sel_ent] && dirty_q[vic_sel_ent]) ? S_WB : S_ALLOC;
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        dirty_q[vic_ent] <= 1'b0;
                        state_q          <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (mem_ready) begin
                        valid_q[vic_ent] <= 1'b1;
                        dirty_q[vic_ent] <= 1'b0;
                        retry_q          <= 1'b1;
                        state_q          <= S_CMP;
                    end
                end
                default: state_q <= S_CMP;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if ((state_q == S_ALLOC) && mem_ready) begin
            data_q[vic_ent] <= mem_rdata;
            tag_q[vic_ent]  <= tag;
        end else if (cmp_hit && proc_write) begin
            data_q[hit_ent][{off, 5'd0} +: WORD_W] <= proc_wdata;
        end
    end

endmodule

// File: tb/tb_cache_setassoc.sv
// tb/tb_cache_setassoc.sv - directed self-checking bench for cache_setassoc
module tb_cache_setassoc;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [31:0]  hit_cnt, miss_cnt;

    int compared = 0;
    int mismatched = 0;

    int           rd_cnt, wr_cnt, wr_seq, wait_cnt, both_high, addr_unstable;
    logic [27:0]  last_rd_addr, last_wr_addr, req_addr;
    logic [127:0] last_wr_data;

    cache_setassoc #(.WAYS(2), .SETS(4), .CNT_W(32)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_read    (proc_read),
        .proc_write   (proc_write),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_rdata   (proc_rdata),
        .proc_stall   (proc_stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [27:0] l);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = {l[23:0], 8'(k)};
        end
        return r;
    endfunction

    // Memory model: answers any request with a one-cycle mem_ready after 3 request cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt = 0; both_high = 0; addr_unstable = 0;
        rd_cnt = 0; wr_cnt = 0; wr_seq = -1;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0; req_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_read && mem_write) both_high++;
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_cnt = 0;
            end else if (mem_read || mem_write) begin
                if (wait_cnt == 0) req_addr = mem_addr;
                else if (mem_addr !== req_addr) addr_unstable++;
                wait_cnt++;
                if (wait_cnt == 3) begin
                    mem_ready = 1'b1;
                    if (mem_read) begin
                        mem_rdata = line_of(mem_addr);
                        rd_cnt++;
                        last_rd_addr = mem_addr;
                    end else begin
                        wr_cnt++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                        wr_seq = rd_cnt;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        proc_reset_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0;
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
        rd_cnt = 0; wr_cnt = 0; wr_seq = -1;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [29:0] addr,
                             input logic [31:0] wd, output logic [31:0] rdata, output int st);
        @(negedge clk);
        proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
        #1;
        st = 0;
        while (proc_stall && st < 200) begin
            @(negedge clk); #1;
            st++;
        end
        if (st >= 200) begin
            compared++; mismatched++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required completion", addr, st);
        end
        rdata = proc_rdata;
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        proc_reset_n = 1'b0; proc_read = 1'b1; proc_addr = 30'h11;
        #1;
        compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
        compared++; if (mem_write !== 1'b0) begin mismatched++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
        compared++; if (mem_addr !== 28'h0) begin mismatched++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        compared++; if (mem_wdata !== 128'h0) begin mismatched++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        compared++; if (proc_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h required 0", proc_rdata); end
        compared++; if (proc_stall !== 1'b1) begin mismatched++; $display("FAIL rst_stall_req: got %b required 1", proc_stall); end
        compared++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin mismatched++; $display("FAIL rst_counters: got %0d/%0d required 0/0", hit_cnt, miss_cnt); end
        proc_read = 1'b0; #1;
        compared++; if (proc_stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall_idle: got %b required 0", proc_stall); end
        @(negedge clk);
        proc_reset_n = 1'b1;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int st;
        do_access(1'b1, 1'b0, 30'h11, 32'h0, rd, st);
        compared++; if (!(st > 0)) begin mismatched++; $display("FAIL miss_stall: got %0d stall cycles required >0", st); end
        compared++; if (rd !== 32'h00000401) begin mismatched++; $display("FAIL miss_rdata: got %h required 00000401", rd); end
        compared++; if (miss_cnt !== 32'd1) begin mismatched++; $display("FAIL miss_cnt: got %0d required 1", miss_cnt); end
        compared++; if (hit_cnt !== 32'd0) begin mismatched++; $display("FAIL miss_hit_cnt: got %0d required 0", hit_cnt); end
        compared++; if (rd_cnt !== 1 || last_rd_addr !== 28'h4) begin mismatched++; $display("FAIL miss_refill: got %0d reads addr %h required 1 read addr 0000004", rd_cnt, last_rd_addr); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int st0, st1;
        do_access(1'b0, 1'b1, 30'h12, 32'hDEADBEEF, rd, st0);
        do_access(1'b1, 1'b0, 30'h12, 32'h0, rd, st1);
        compared++; if (st0 !== 0 || st1 !== 0) begin mismatched++; $display("FAIL hit_stall: got %0d/%0d required 0/0", st0, st1); end
        compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL hit_rdata: got %h required deadbeef", rd); end
        compared++; if (hit_cnt !== 32'd2) begin mismatched++; $display("FAIL hit_cnt: got %0d required 2", hit_cnt); end
        compared++; if (rd_cnt !== 1 || wr_cnt !== 0) begin mismatched++; $display("FAIL hit_no_mem: got %0d reads %0d writes required 1/0", rd_cnt, wr_cnt); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd; int st;
        apply_reset();
        do_access(1'b1, 1'b0, 30'h00, 32'h0, rd, st);
        do_access(1'b1, 1'b0, 30'h10, 32'h0, rd, st);
        do_access(1'b0, 1'b1, 30'h00, 32'hCAFEF00D, rd, st);
        do_access(1'b1, 1'b0, 30'h10, 32'h0, rd, st);
        do_access(1'b1, 1'b0, 30'h20, 32'h0, rd, st);
        compared++; if (wr_cnt !== 1 || last_wr_addr !== 28'h0) begin mismatched++; $display("FAIL evict_wb: got %0d writes addr %h required 1 write addr 0000000", wr_cnt, last_wr_addr); end
        compared++; if (last_wr_data !== {32'h3, 32'h2, 32'h1, 32'hCAFEF00D}) begin mismatched++; $display("FAIL evict_wdata: got %h required %h", last_wr_data, {32'h3, 32'h2, 32'h1, 32'hCAFEF00D}); end
        compared++; if (wr_seq !== 2 || rd_cnt !== 3 || last_rd_addr !== 28'h8) begin mismatched++; $display("FAIL evict_order: got wb after %0d reads, %0d reads, last %h required 2, 3, 0000008", wr_seq, rd_cnt, last_rd_addr); end
        compared++; if (rd !== 32'h00000800) begin mismatched++; $display("FAIL evict_rdata: got %h required 00000800", rd); end
        compared++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd3) begin mismatched++; $display("FAIL evict_counts: got %0d/%0d required 2/3", hit_cnt, miss_cnt); end
    endtask

    task automatic test_lru_order();
        logic [31:0] rd; int st;
        apply_reset();
        do_access(1'b1, 1'b0, 30'h00, 32'h0, rd, st);
        do_access(1'b1, 1'b0, 30'h10, 32'h0, rd, st);
        do_access(1'b1, 1'b0, 30'h00, 32'h0, rd, st);
        do_access(1'b1, 1'b0, 30'h20, 32'h0, rd, st);
        compared++; if (last_rd_addr !== 28'h8 || wr_cnt !== 0) begin mismatched++; $display("FAIL lru_refill: got addr %h writes %0d required 0000008/0", last_rd_addr, wr_cnt); end
        do_access(1'b1, 1'b0, 30'h00, 32'h0, rd, st);
        compared++; if (st !== 0 || rd !== 32'h00000000) begin mismatched++; $display("FAIL lru_a_hit: got stall %0d rdata %h required 0/00000000", st, rd); end
        do_access(1'b1, 1'b0, 30'h11, 32'h0, rd, st);
        compared++; if (!(st > 0) || rd !== 32'h00000401) begin mismatched++; $display("FAIL lru_b_evicted: got stall %0d rdata %h required >0/00000401", st, rd); end
        compared++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd4) begin mismatched++; $display("FAIL lru_counts: got %0d/%0d required 2/4", hit_cnt, miss_cnt); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; int st; int n;
        apply_reset();
        @(negedge clk);
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h30;
        n = 0;
        while (!mem_read && n < 20) begin @(negedge clk); n++; end
        compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL abort_refill_start: got mem_read %b required 1", mem_read); end
        proc_reset_n = 1'b0;
        #1;
        compared++; if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin mismatched++; $display("FAIL abort_mem: got read %b addr %h required 0/0000000", mem_read, mem_addr); end
        compared++; if (proc_stall !== 1'b1 || miss_cnt !== 32'd0) begin mismatched++; $display("FAIL abort_state: got stall %b miss %0d required 1/0", proc_stall, miss_cnt); end
        @(negedge clk);
        proc_reset_n = 1'b1;
        do_access(1'b1, 1'b0, 30'h30, 32'h0, rd, st);
        compared++; if (!(st > 0) || rd !== 32'h00000C00) begin mismatched++; $display("FAIL abort_retry: got stall %0d rdata %h required >0/00000c00", st, rd); end
        compared++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin mismatched++; $display("FAIL abort_counts: got miss %0d hit %0d required 1/0", miss_cnt, hit_cnt); end
    endtask

    task automatic test_read_write_both();
        logic [31:0] rd; int st;
        apply_reset();
        do_access(1'b1, 1'b0, 30'h40, 32'h0, rd, st);
        do_access(1'b1, 1'b1, 30'h41, 32'h12345678, rd, st);
        compared++; if (st !== 0) begin mismatched++; $display("FAIL both_stall: got %0d required 0", st); end
        do_access(1'b1, 1'b0, 30'h41, 32'h0, rd, st);
        compared++; if (rd !== 32'h12345678) begin mismatched++; $display("FAIL both_written: got %h required 12345678", rd); end
        do_access(1'b1, 1'b0, 30'h40, 32'h0, rd, st);
        compared++; if (rd !== 32'h00001000) begin mismatched++; $display("FAIL both_neighbour: got %h required 00001000", rd); end
        compared++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1 || wr_cnt !== 0) begin mismatched++; $display("FAIL both_counts: got %0d/%0d/%0d required 3/1/0", hit_cnt, miss_cnt, wr_cnt); end
    endtask

    task automatic test_bus_rules();
        compared++; if (both_high !== 0) begin mismatched++; $display("FAIL bus_exclusive: got %0d overlap cycles required 0", both_high); end
        compared++; if (addr_unstable !== 0) begin mismatched++; $display("FAIL bus_addr_stable: got %0d changes required 0", addr_unstable); end
    endtask

    initial begin
        proc_reset_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0;
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_lru_order();
        test_reset_abort();
        test_read_write_both();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_setassoc.md
Name: cache_setassoc

Overview:
Parametrised write-back, write-allocate N-way set-associative data cache. It is the successor to the 8-entry fully-associative cache and sits between the pipeline's data port and the 128-bit line-wide memory bus. Tag lookup is by set index, replacement is true-LRU per set, and two performance counters report hits and misses. The processor and memory interfaces keep the existing protocol, so the block drops in without pipeline changes.

Parameters:
WAYS, 2, associativity; power of 2, range 2..8
SETS, 4, sets per way; power of 2, at least 2
IDX_W, log2(SETS), derived set-index width
TAG_W, 28-IDX_W, derived tag width
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
proc_reset_n  in  1  asynchronous, active-low reset
proc_read  in  1  read request, word granularity
proc_write  in  1  write request; wins if proc_read is also high
proc_addr  in  30  word address: [29:2+IDX_W] tag, [1+IDX_W:2] index, [1:0] word offset
proc_wdata  in  32  write data
proc_rdata  out  32  read data; valid when request is high and proc_stall is 0
proc_stall  out  1  stall the pipeline
mem_read  out  1  line refill request
mem_write  out  1  line write-back request
mem_addr  out  28  line address
mem_wdata  out  128  write-back line
mem_rdata  in  128  refill line
mem_ready  in  1  single-cycle completion pulse
hit_cnt  out  CNT_W  number of accesses counted as hits
miss_cnt  out  CNT_W  number of accesses counted as misses

Behaviour:
- Reset is asynchronous, active-low. On assertion, immediately: state=S_CMP; all valid and dirty bits cleared; LRU age of way i = i in every set; counters=0; retry flag=0; victim register=0.
- While in reset, outputs are: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0. proc_stall equals the request (proc_read|proc_write).
- Data RAM is not cleared on reset.
- States:
  - S_CMP: lookup/compare tags.
  - S_WB: write back the dirty victim.
  - S_ALLOC: refill the line from memory.
- Hit condition: valid[set][w] and tag[set][w] equals the address tag, for exactly one way w.
- S_CMP, no request: proc_stall=0; no state change.
- S_CMP, hit: zero extra latency.
  - proc_stall=0.
  - Read: proc_rdata = word proc_addr[1:0] of the line (word 0 = bits [31:0]), combinational in the same cycle.
  - Write: at the clock edge, the word is updated and dirty is set.
  - LRU: the hit way's age becomes 0; every way in the set with a smaller age increments.
  - If the retry flag is clear, hit_cnt increments; otherwise the flag is cleared and no hit is counted.
- S_CMP, miss:
  - proc_stall=1; miss_cnt increments.
  - Victim is latched: the lowest-index invalid way, otherwise the way with age WAYS-1.
  - Next state is S_WB if the victim is valid and dirty, otherwise S_ALLOC.
- S_WB:
  - proc_stall=1; mem_write=1; mem_addr={victim tag, index}; mem_wdata=victim line.
  - When mem_ready is seen: mem_write drops in that same cycle, the victim's dirty bit is cleared, and next state is S_ALLOC.
- S_ALLOC:
  - proc_stall=1; mem_read=1; mem_addr=proc_addr[29:2].
  - When mem_ready is seen: mem_read drops combinationally; mem_rdata is written to the victim way; valid=1, dirty=0, tag is written; retry flag is set; next state is S_CMP.
  - The retry compare then hits and completes the access, including the write merge and the LRU update.
- Memory latency is unbounded. mem_read/mem_write and mem_addr stay stable until mem_ready. mem_read and mem_write are never high together.
- The processor must hold proc_addr, proc_wdata and the request stable while proc_stall=1.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-S_WB or mid-S_ALLOC aborts the transaction. The memory model must tolerate the dropped request.

Decomposition:
- Package cache_pkg:
  - state enum {S_CMP, S_WB, S_ALLOC};
  - LINE_W=128, WORD_W=32, LINE_ADDR_W=28, PROC_ADDR_W=30.
- Sub-module cache_lru, one instance per set (generate loop), parameter WAYS:
  - inputs: access strobe, access way;
  - output: victim way;
  - holds the age registers; resets to ages 0..WAYS-1.
- Tag, valid, dirty and data arrays are flat register arrays in cache_setassoc.

Test Plan (defaults WAYS=2, SETS=4; memory model returns line L with word k = {L[23:0], k[7:0]}, mem_ready after 3 cycles):
1. Reset, then read 0x00011 → miss_cnt=1. Observe mem_read with mem_addr=0x0004 until mem_ready. Then proc_rdata=0x00000401, proc_stall=0 on the retry cycle, hit_cnt=0.
2. Write 0xDEADBEEF to 0x00012, then read 0x00012 → both hit, no mem traffic, rdata=0xDEADBEEF, hit_cnt=2.
3. Dirty eviction: read 0x00, 0x10, write 0x00, read 0x10, read 0x20 (all set 0). The third line evicts line 0x0 (LRU, dirty): mem_write with mem_addr=0x0000 and mem_wdata word 0 holding the written value, then mem_read with mem_addr=0x0008.
4. LRU order: read A=0x00, B=0x10, A, then C=0x20 → B's way is refilled; a subsequent read of A hits.
5. Assert proc_reset_n=0 for 1 cycle mid-S_ALLOC → mem_read=0 immediately, state S_CMP, counters 0. The next read of the same address misses.
6. Request both read and write on a hit → treated as a write: the word is updated and proc_rdata is ignored.
